// File: rtl/pc_gen_pkg.sv
// ---------------------------------------------------------------------------
// pc_gen_pkg
// Shared definitions for the program-counter generator:
//   INST_ADDR_W    - instruction address bus width
//   CPU_RESET_ADDR - PC value loaded while reset is active
//   RST_ENABLE     - level of rstn that holds the block in reset
//   pc_state_e     - 2-bit FSM state encodings
// ---------------------------------------------------------------------------
package pc_gen_pkg;

  localparam int unsigned INST_ADDR_W    = 32;
  localparam logic [31:0] CPU_RESET_ADDR = 32'h0000_0000;
  localparam logic        RST_ENABLE     = 1'b0;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } pc_state_e;

endpackage : pc_gen_pkg

// File: rtl/pc_gen_if.sv
// ---------------------------------------------------------------------------
// pc_gen_if
// Fetch request port between the PC generator (master) and the fetch unit
// (slave).
//   req_valid_o - fetch request valid        (master -> slave)
//   req_ready_i - fetch port accepts request (slave -> master)
//   pc_o        - current PC / fetch address (master -> slave)
//   misalign_o  - redirect target was not step-aligned, one-cycle pulse
// ---------------------------------------------------------------------------
interface pc_gen_if
  import pc_gen_pkg::*;
#(
  parameter int unsigned ADDR_W = INST_ADDR_W
);

  logic              req_valid_o;
  logic              req_ready_i;
  logic [ADDR_W-1:0] pc_o;
  logic              misalign_o;

  modport master (
    output req_valid_o,
    input  req_ready_i,
    output pc_o,
    output misalign_o
  );

  modport slave (
    input  req_valid_o,
    output req_ready_i,
    input  pc_o,
    input  misalign_o
  );

endinterface : pc_gen_if

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen
// Program-counter generator for the fetch stage. Issues sequential fetch
// requests, stalls on the fetch-port handshake and on the PC-stage hold bit,
// and takes trap/jump redirects (trap has priority).
// Ports:
//   clk          - clock, rising edge
//   rstn         - asynchronous active-low reset
//   hold_en_i    - ctrl hold bus; bit 0 stalls the PC stage
//   jump_en_i    - EX-stage redirect request
//   jump_addr_i  - EX-stage redirect target
//   trap_en_i    - trap redirect request
//   trap_addr_i  - trap vector
//   fetch_if     - fetch request port (valid/ready/pc/misalign)
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned       ADDR_W     = INST_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(CPU_RESET_ADDR),
  parameter int unsigned       STEP       = 4,
  parameter int unsigned       HOLD_W     = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [HOLD_W-1:0] hold_en_i,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              trap_en_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
  pc_gen_if.master          fetch_if
);

  localparam logic [ADDR_W-1:0] STEP_INC = ADDR_W'(STEP);
  // Address bits below log2(STEP); these must be zero in any fetch address.
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(STEP - 1);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              misalign_q, misalign_d;

  logic              hold_s;
  logic              redirect_s;
  logic              handshake_s;
  logic [ADDR_W-1:0] target_s;
  logic [ADDR_W-1:0] target_aligned_s;
  logic              unused_hold_s;

  assign hold_s        = hold_en_i[0];
  // Only bit 0 of the hold bus belongs to the PC stage.
  assign unused_hold_s = ^hold_en_i;

  // Redirect selection: trap wins over jump when both are requested.
  assign redirect_s       = trap_en_i | jump_en_i;
  assign target_s         = trap_en_i ? trap_addr_i : jump_addr_i;
  assign target_aligned_s = target_s & ~LOW_MASK;
  assign handshake_s      = valid_q & fetch_if.req_ready_i;

  // Next-state, next-PC and misalign pulse computation.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    valid_d    = 1'b0;

    case (state_q)
      ST_BOOT: begin
        // A redirect during boot is honoured, but boot always ends in RUN.
        state_d = ST_RUN;
        if (redirect_s) begin
          pc_d = target_aligned_s;
        end else begin
          pc_d = pc_q;
        end
      end

      ST_RUN: begin
        // A redirect discards any unaccepted address; a handshake advances
        // even when hold arrives in the same cycle.
        if (redirect_s) begin
          pc_d = target_aligned_s;
        end else if (handshake_s) begin
          pc_d = pc_q + STEP_INC;
        end else begin
          pc_d = pc_q;
        end
        if (hold_s) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_HOLD: begin
        if (redirect_s) begin
          pc_d = target_aligned_s;
        end else begin
          pc_d = pc_q;
        end
        if (hold_s) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_BOOT;
        pc_d    = RESET_ADDR;
      end
    endcase

    if (redirect_s && ((target_s & LOW_MASK) != '0)) begin
      misalign_d = 1'b1;
    end else begin
      misalign_d = 1'b0;
    end

    // A request is offered exactly in RUN; keeping it in its own flop keeps
    // the output free of decode logic.
    if (state_d == ST_RUN) begin
      valid_d = 1'b1;
    end else begin
      valid_d = 1'b0;
    end
  end

  // State, PC and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (rstn == RST_ENABLE) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_ADDR;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign fetch_if.req_valid_o = valid_q;
  assign fetch_if.pc_o        = pc_q;
  assign fetch_if.misalign_o  = misalign_q;

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen
// Self-checking bench for pc_gen (ADDR_W=32, RESET_ADDR=0, STEP=4). A
// behavioural model tracks "still booting", "held" and the expected PC and
// is compared against the DUT after every clock; directed vectors add
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_pc_gen;

  localparam int unsigned AW   = 32;
  localparam int unsigned STP  = 4;
  localparam logic [31:0] RSTA = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [4:0]    hold_en = 5'b00000;
  logic          jump_en = 1'b0;
  logic [AW-1:0] jump_addr = 32'h0;
  logic          trap_en = 1'b0;
  logic [AW-1:0] trap_addr = 32'h0;

  pc_gen_if #(.ADDR_W(AW)) fetch_if ();

  pc_gen #(
    .ADDR_W    (AW),
    .RESET_ADDR(RSTA),
    .STEP      (STP),
    .HOLD_W    (5)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .hold_en_i  (hold_en),
    .jump_en_i  (jump_en),
    .jump_addr_i(jump_addr),
    .trap_en_i  (trap_en),
    .trap_addr_i(trap_addr),
    .fetch_if   (fetch_if.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: booting / held flags, expected PC (kept wide, wrapped explicitly).
  bit      m_boot;
  bit      m_held;
  longint  m_pc;
  bit      m_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot = 1'b1;
    m_held = 1'b0;
    m_pc   = longint'(RSTA);
    m_mis  = 1'b0;
  endtask

  // One clock edge of the specified behaviour, from the inputs at the edge.
  task automatic model_step();
    bit     redir;
    longint tgt;
    bit     fire;
    redir = trap_en | jump_en;
    tgt   = trap_en ? longint'(trap_addr) : longint'(jump_addr);
    if (m_boot) begin
      m_boot = 1'b0;
      m_held = 1'b0;
      if (redir) m_pc = tgt - (tgt % STP);
    end else begin
      fire = !m_held && fetch_if.req_ready_i;
      if (redir)     m_pc = tgt - (tgt % STP);
      else if (fire) m_pc = (m_pc + STP) % (64'd1 << AW);
      m_held = hold_en[0];
    end
    m_mis = redir && ((tgt % STP) != 0);
  endtask

  task automatic model_cmp();
    chk("model_pc",    fetch_if.pc_o, m_pc[31:0]);
    chk("model_valid", {31'd0, fetch_if.req_valid_o}, {31'd0, (!m_boot && !m_held)});
    chk("model_mis",   {31'd0, fetch_if.misalign_o}, {31'd0, m_mis});
  endtask

  // Advance one clock: update the model at the edge, compare at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rstn) model_reset();
    else       model_step();
    @(negedge clk);
    model_cmp();
  endtask

  task automatic lit(input string name, input logic [31:0] pc_e, input logic v_e, input logic m_e);
    chk({name, "_pc"},    fetch_if.pc_o, pc_e);
    chk({name, "_valid"}, {31'd0, fetch_if.req_valid_o}, {31'd0, v_e});
    chk({name, "_mis"},   {31'd0, fetch_if.misalign_o}, {31'd0, m_e});
  endtask

  initial begin
    fetch_if.req_ready_i = 1'b1;
    model_reset();
    tick();
    tick();
    lit("reset", 32'h0, 1'b0, 1'b0);

    // Reset release with ready high: sequential fetches.
    rstn = 1'b1;
    tick(); lit("boot_c1", 32'h0, 1'b1, 1'b0);
    tick(); lit("seq4",    32'h4, 1'b1, 1'b0);
    tick(); lit("seq8",    32'h8, 1'b1, 1'b0);
    tick();
    tick(); lit("seq10",   32'h10, 1'b1, 1'b0);

    // Fetch-port stall holds address and valid.
    fetch_if.req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); lit("stall", 32'h10, 1'b1, 1'b0);
    end
    fetch_if.req_ready_i = 1'b1;
    tick(); lit("unstall", 32'h14, 1'b1, 1'b0);
    fetch_if.req_ready_i = 1'b0;

    // Jump while stalled, aligned then misaligned target.
    jump_en = 1'b1; jump_addr = 32'h200;
    tick(); lit("jump", 32'h200, 1'b1, 1'b0);
    jump_addr = 32'h202;
    tick(); lit("jump_mis", 32'h200, 1'b1, 1'b1);
    jump_en = 1'b0;
    tick(); lit("mis_pulse_end", 32'h200, 1'b1, 1'b0);

    // Trap beats jump.
    trap_en = 1'b1; trap_addr = 32'h80; jump_en = 1'b1; jump_addr = 32'h200;
    tick(); lit("trap_prio", 32'h80, 1'b1, 1'b0);
    trap_en = 1'b0;

    // Hold for four cycles at 0x20 with a jump in the middle.
    jump_addr = 32'h20;
    tick(); lit("to20", 32'h20, 1'b1, 1'b0);
    jump_en = 1'b0;
    hold_en = 5'b00001;
    tick(); lit("hold1", 32'h20, 1'b0, 1'b0);
    jump_en = 1'b1; jump_addr = 32'h300;
    tick(); lit("hold_jump", 32'h300, 1'b0, 1'b0);
    jump_en = 1'b0;
    tick(); lit("hold3", 32'h300, 1'b0, 1'b0);
    tick(); lit("hold4", 32'h300, 1'b0, 1'b0);
    hold_en = 5'b00000;
    tick(); lit("hold_rel", 32'h300, 1'b1, 1'b0);

    // Hold coincident with a handshake: advance, then hold.
    fetch_if.req_ready_i = 1'b1; hold_en = 5'b00001;
    tick(); lit("hold_hs", 32'h304, 1'b0, 1'b0);
    fetch_if.req_ready_i = 1'b0; hold_en = 5'b00000;
    tick(); lit("hold_hs_rel", 32'h304, 1'b1, 1'b0);

    // Misaligned trap vector.
    trap_en = 1'b1; trap_addr = 32'h83;
    tick(); lit("trap_mis", 32'h80, 1'b1, 1'b1);
    trap_en = 1'b0;

    // Wrap at the top of the address space.
    jump_en = 1'b1; jump_addr = 32'hFFFF_FFFC;
    tick(); lit("top", 32'hFFFF_FFFC, 1'b1, 1'b0);
    jump_en = 1'b0; fetch_if.req_ready_i = 1'b1;
    tick(); lit("wrap", 32'h0, 1'b1, 1'b0);
    fetch_if.req_ready_i = 1'b0;

    // Asynchronous reset mid-stall with a redirect pending.
    jump_en = 1'b1; jump_addr = 32'h40;
    tick(); lit("to40", 32'h40, 1'b1, 1'b0);
    jump_addr = 32'h500;
    #2 rstn = 1'b0;
    #1 lit("async_rst", RSTA, 1'b0, 1'b0);
    model_reset();
    jump_en = 1'b0;
    tick();
    rstn = 1'b1;
    tick(); lit("rst_reboot", RSTA, 1'b1, 1'b0);

    // Mixed traffic checked only against the model.
    for (int i = 0; i < 300; i++) begin
      fetch_if.req_ready_i = ($urandom_range(0, 3) != 0);
      hold_en   = {4'b0000, ($urandom_range(0, 5) == 0)};
      jump_en   = ($urandom_range(0, 9) == 0);
      trap_en   = ($urandom_range(0, 19) == 0);
      jump_addr = $urandom;
      trap_addr = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_pc_gen

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter ADDR_W, default 32, PC and address width in bits.
REQ-002 Parameter RESET_ADDR, default 32'h0000_0000, PC value loaded at reset; shall be STEP-aligned.
REQ-003 Parameter STEP, default 4, byte increment per accepted fetch; legal values 2 and 4.
REQ-004 Parameter HOLD_W, default 5, width of the ctrl hold bus.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rstn  in  1  reset, asynchronous assert, active-low (`RstEnable` level).
REQ-007 hold_en_i  in  HOLD_W  ctrl hold bus; only bit 0 (PC stage stall) is used by this block.
REQ-008 jump_en_i  in  1  EX-stage redirect request.
REQ-009 jump_addr_i  in  ADDR_W  EX-stage redirect target.
REQ-010 trap_en_i  in  1  trap/exception redirect request.
REQ-011 trap_addr_i  in  ADDR_W  trap vector.
REQ-012 req_valid_o  out  1  fetch request valid.
REQ-013 req_ready_i  in  1  fetch port accepts request.
REQ-014 pc_o  out  ADDR_W  current PC; also the fetch request address.
REQ-015 misalign_o  out  1  one-cycle pulse: redirect target not STEP-aligned.

Function
REQ-016 FSM states: BOOT, RUN, HOLD.
REQ-017 BOOT: req_valid_o=0; unconditional transition to RUN next cycle (first fetch issued one cycle after reset release).
REQ-018 RUN: req_valid_o=1; handshake = req_valid_o & req_ready_i.
REQ-019 On handshake without redirect, pc_o <= pc_o + STEP next cycle, modulo 2^ADDR_W (max-STEP+STEP wraps to 0).
REQ-020 Without handshake and without redirect, pc_o and req_valid_o shall hold (address stable while stalled by fetch port).
REQ-021 Redirect priority: trap_en_i > jump_en_i > hold > sequential advance.
REQ-022 Redirect (trap or jump) in any state except BOOT: pc_o <= target next cycle regardless of req_ready_i; in-flight unaccepted address is discarded.
REQ-023 Redirect in BOOT: target captured, pc_o <= target, FSM still enters RUN.
REQ-024 Redirect target low bits below log2(STEP) forced to 0; misalign_o=1 in following cycle if any were set, else 0.
REQ-025 hold_en_i[0]=1 in RUN with req_valid_o=1 and no handshake this cycle: enter HOLD, req_valid_o=0 next cycle.
REQ-026 hold_en_i[0]=1 coincident with handshake: advance per REQ-019, then enter HOLD.
REQ-027 HOLD: req_valid_o=0, pc_o frozen except redirect (REQ-022 applies, stays in HOLD).
REQ-028 HOLD -> RUN when hold_en_i[0]=0; req_valid_o=1 the next cycle with the held/redirected pc_o.
REQ-029 Simultaneous trap_en_i and jump_en_i: trap target used, jump dropped.
REQ-030 Redirect with hold_en_i[0]=1: PC updated, FSM goes/stays HOLD.
REQ-031 No combinational path from any input to req_valid_o or pc_o; all outputs registered.

Reset
REQ-032 rstn low: pc_o=RESET_ADDR, req_valid_o=0, misalign_o=0, state=BOOT, immediately (asynchronous).
REQ-033 rstn asserted mid-request: request withdrawn at once; no pending redirect survives.

Structure
REQ-034 Shared defines file holds `InstAddrBus`, `CpuResetAddr`, `RstEnable` and the FSM state encodings (2-bit).
REQ-035 Single flat module; no sub-module needed.

Verification
REQ-036 Reset release, ready=1 constantly -> valid rises cycle 1, pc_o 0x0,0x4,0x8 on consecutive cycles.
REQ-037 ready=0 for 3 cycles at pc 0x10 -> pc_o stays 0x10, valid stays 1; ready=1 -> 0x14 next cycle.
REQ-038 jump_en_i=1, target 0x200, ready=0 -> pc_o=0x200 next cycle, misalign_o=0; target 0x202 (STEP=4) -> pc_o=0x200, misalign_o=1 one cycle.
REQ-039 trap 0x80 and jump 0x200 same cycle -> pc_o=0x80.
REQ-040 hold_en_i=5'b00001 for 4 cycles at pc 0x20, jump 0x300 mid-hold -> valid=0 throughout, on release valid=1 with pc_o=0x300.
REQ-041 ADDR_W=32, pc 0xFFFF_FFFC, handshake -> pc_o=0x0; rstn pulse mid-stall -> pc_o=RESET_ADDR, valid=0 asynchronously.
